// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and types for the five-stage pipeline control slice.
// Stage-info dest fields are PIPE_AW_MAX bits wide; users must keep REG_AW <= PIPE_AW_MAX.
package pipe_pkg;

  localparam int unsigned PIPE_AW_MAX = 8;

  // Forwarding-select encoding presented to the operand muxes in the datapath.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // Stage indices; also the bit positions inside stage_valid.
  localparam logic [1:0] STG_ID  = 2'd0;
  localparam logic [1:0] STG_EX  = 2'd1;
  localparam logic [1:0] STG_MEM = 2'd2;
  localparam logic [1:0] STG_WB  = 2'd3;

  // Producer information carried alongside each in-flight instruction.
  typedef struct packed {
    logic [PIPE_AW_MAX-1:0] dest;
    logic                   we;
    logic                   is_load;
  } stage_info_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// hazard_match: combinational RAW matcher for one ID source operand.
// PIPE_FORWARD_EN defined: forward from EX/MEM/WB, stall only on load-use.
// PIPE_FORWARD_EN undefined: no forwarding, any in-flight producer stalls ID.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_use,
  input  logic              ex_v,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic              mem_v,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_we,
  input  logic              wb_v,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_we,
  output logic [1:0]        sel,
  output logic              stall
);

  logic live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;
  logic load_use;

  // Compare the operand against each older producer; the youngest match wins.
  always_comb begin
    live     = src_use && (src_addr != '0);
    hit_ex   = live && ex_v  && ex_we  && (ex_dest  == src_addr);
    hit_mem  = live && mem_v && mem_we && (mem_dest == src_addr);
    hit_wb   = live && wb_v  && wb_we  && (wb_dest  == src_addr);
    load_use = hit_ex && ex_is_load;
    sel      = FWD_RF;
`ifdef PIPE_FORWARD_EN
    if (hit_ex) begin
      sel = FWD_EX;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end
    stall = load_use;
`else
    // Without forwarding a load-use match is just one case of any match.
    stall = load_use || hit_ex || hit_mem || hit_wb;
`endif
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: valid/allowin chain, RAW hazard stall/forward control and
// redirect flush for the IF/ID/EX/MEM/WB pipeline, plus saturating perf counters.
// Optional feature macro: PIPE_FORWARD_EN (operand forwarding).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_ready_go,
  input  logic [NSRC*REG_AW-1:0] id_src_addr,
  input  logic [NSRC-1:0]        id_src_use,
  input  logic [REG_AW-1:0]      id_dest,
  input  logic                   id_we,
  input  logic                   id_is_load,
  input  logic                   ex_busy,
  input  logic                   ex_redirect,
  output logic                   pc_we,
  output logic                   id_ex_we,
  output logic                   ex_mem_we,
  output logic                   mem_wb_we,
  output logic [3:0]             stage_valid,
  output logic [NSRC*2-1:0]      fwd_sel,
  output logic                   rf_we_wb,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam logic WB_ALLOWIN = 1'b1;

  logic [3:0]       v_q;
  logic [3:0]       v_d;
  stage_info_t      info_q [STG_EX:STG_WB];
  stage_info_t      info_d [STG_EX:STG_WB];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  logic [NSRC-1:0]   op_stall;
  logic [NSRC*2-1:0] op_sel;

  logic flush;
  logic hz_stall;
  logic id_ready_go;
  logic mem_allowin;
  logic ex_allowin;
  logic id_allowin;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    hazard_match #(
      .REG_AW(REG_AW)
    ) u_match (
      .src_addr  (id_src_addr[i*REG_AW +: REG_AW]),
      .src_use   (id_src_use[i]),
      .ex_v      (v_q[STG_EX]),
      .ex_dest   (info_q[STG_EX].dest[REG_AW-1:0]),
      .ex_we     (info_q[STG_EX].we),
      .ex_is_load(info_q[STG_EX].is_load),
      .mem_v     (v_q[STG_MEM]),
      .mem_dest  (info_q[STG_MEM].dest[REG_AW-1:0]),
      .mem_we    (info_q[STG_MEM].we),
      .wb_v      (v_q[STG_WB]),
      .wb_dest   (info_q[STG_WB].dest[REG_AW-1:0]),
      .wb_we     (info_q[STG_WB].we),
      .sel       (op_sel[i*2 +: 2]),
      .stall     (op_stall[i])
    );
  end

  // Handshake chain; a redirect overrides any ID stall so the ID slot is freed and killed.
  always_comb begin
    flush       = v_q[STG_EX] & ex_redirect & ~ex_busy;
    hz_stall    = v_q[STG_ID] & (|op_stall) & ~flush;
    id_ready_go = ~hz_stall;
    mem_allowin = ~v_q[STG_MEM] | WB_ALLOWIN;
    ex_allowin  = ~v_q[STG_EX] | (~ex_busy & mem_allowin);
    id_allowin  = ~v_q[STG_ID] | (id_ready_go & ex_allowin);
  end

  // Output drive; enables and selects are held low while reset is asserted.
  always_comb begin
    pc_we       = ~reset & ((if_ready_go & id_allowin) | flush);
    id_ex_we    = ~reset & ex_allowin;
    ex_mem_we   = ~reset & mem_allowin;
    mem_wb_we   = ~reset;
    stage_valid = v_q;
    fwd_sel     = reset ? '0 : op_sel;
    rf_we_wb    = ~reset & v_q[STG_WB] & info_q[STG_WB].we;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end

  // Next-state: advance valid bits and producer info, bump saturating counters.
  always_comb begin
    v_d         = v_q;
    info_d      = info_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    v_d[STG_WB]    = v_q[STG_MEM];
    info_d[STG_WB] = info_q[STG_MEM];
    if (mem_allowin) begin
      v_d[STG_MEM]    = v_q[STG_EX] & ~ex_busy;
      info_d[STG_MEM] = info_q[STG_EX];
    end
    if (ex_allowin) begin
      v_d[STG_EX]    = v_q[STG_ID] & id_ready_go & ~flush;
      info_d[STG_EX] = '{dest: PIPE_AW_MAX'(id_dest), we: id_we, is_load: id_is_load};
    end
    if (id_allowin) begin
      v_d[STG_ID] = if_ready_go & ~flush;
    end

    if (hz_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    if (reset) begin
      v_d         = '0;
      info_d      = '{default: '0};
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    v_q         <= v_d;
    info_q      <= info_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by random traffic, every cycle
// compared against an occupancy-based pipeline model kept in the bench.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int          SAT    = (1 << CNT_W) - 1;
`ifdef PIPE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   if_ready_go;
  logic [NSRC*REG_AW-1:0] id_src_addr;
  logic [NSRC-1:0]        id_src_use;
  logic [REG_AW-1:0]      id_dest;
  logic                   id_we;
  logic                   id_is_load;
  logic                   ex_busy;
  logic                   ex_redirect;
  logic                   pc_we;
  logic                   id_ex_we;
  logic                   ex_mem_we;
  logic                   mem_wb_we;
  logic [3:0]             stage_valid;
  logic [NSRC*2-1:0]      fwd_sel;
  logic                   rf_we_wb;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW),
    .NSRC  (NSRC),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_ready_go(if_ready_go),
    .id_src_addr(id_src_addr),
    .id_src_use (id_src_use),
    .id_dest    (id_dest),
    .id_we      (id_we),
    .id_is_load (id_is_load),
    .ex_busy    (ex_busy),
    .ex_redirect(ex_redirect),
    .pc_we      (pc_we),
    .id_ex_we   (id_ex_we),
    .ex_mem_we  (ex_mem_we),
    .mem_wb_we  (mem_wb_we),
    .stage_valid(stage_valid),
    .fwd_sel    (fwd_sel),
    .rf_we_wb   (rf_we_wb),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Model: slot 0 = ID, 1 = EX, 2 = MEM, 3 = WB. Producer fields are used for slots 1..3.
  bit m_v    [4];
  int m_dest [4];
  bit m_we   [4];
  bit m_ld   [4];
  int m_stall;
  int m_flush;

  task automatic model_clear();
    for (int s = 0; s < 4; s++) begin
      m_v[s] = 0; m_dest[s] = 0; m_we[s] = 0; m_ld[s] = 0;
    end
    m_stall = 0;
    m_flush = 0;
  endtask

  // Compare the DUT against the model for the current inputs, then advance the model.
  task automatic check_and_advance();
    int  sel [NSRC];
    int  addr;
    bit  need_stall, flush, hz;
    bit  leave [4];
    bit  accept [4];
    int  exp_fwd;
    bit  e_pc, e_idex, e_exmem, e_memwb, e_rfwe;

    need_stall = 0;
    exp_fwd    = 0;
    for (int i = 0; i < int'(NSRC); i++) begin
      sel[i] = 0;
      addr   = int'(id_src_addr[i*REG_AW +: REG_AW]);
      if (id_src_use[i] && addr != 0) begin
        for (int s = 1; s <= 3; s++)
          if (sel[i] == 0 && m_v[s] && m_we[s] && m_dest[s] == addr) sel[i] = s;
      end
      if (sel[i] != 0) need_stall |= FWD ? (sel[i] == 1 && m_ld[1]) : 1'b1;
      if (FWD) exp_fwd |= sel[i] << (2 * i);
    end
    flush = m_v[1] && ex_redirect && !ex_busy;
    hz    = m_v[0] && need_stall && !flush;

    // A slot accepts a new occupant if it is empty or its occupant moves on.
    accept[3] = 1;
    leave[3]  = m_v[3];
    accept[2] = 1;
    leave[2]  = m_v[2];
    leave[1]  = m_v[1] && !ex_busy && accept[2];
    accept[1] = !m_v[1] || leave[1];
    leave[0]  = m_v[0] && !hz && accept[1];
    accept[0] = !m_v[0] || leave[0];

    e_pc    = !reset && ((if_ready_go && accept[0]) || flush);
    e_idex  = !reset && accept[1];
    e_exmem = !reset && accept[2];
    e_memwb = !reset;
    e_rfwe  = !reset && m_v[3] && m_we[3];
    if (reset) exp_fwd = 0;

    check("stage_valid", 32'(stage_valid), {28'd0, m_v[3], m_v[2], m_v[1], m_v[0]});
    check("pc_we",       32'(pc_we),       32'(e_pc));
    check("id_ex_we",    32'(id_ex_we),    32'(e_idex));
    check("ex_mem_we",   32'(ex_mem_we),   32'(e_exmem));
    check("mem_wb_we",   32'(mem_wb_we),   32'(e_memwb));
    check("fwd_sel",     32'(fwd_sel),     32'(exp_fwd));
    check("rf_we_wb",    32'(rf_we_wb),    32'(e_rfwe));
    check("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    check("flush_cnt",   32'(flush_cnt),   32'(m_flush));

    if (reset) begin
      model_clear();
    end else begin
      if (hz && m_stall < SAT) m_stall++;
      if (flush && m_flush < SAT) m_flush++;
      m_v[3] = m_v[2]; m_dest[3] = m_dest[2]; m_we[3] = m_we[2]; m_ld[3] = m_ld[2];
      m_v[2] = leave[1]; m_dest[2] = m_dest[1]; m_we[2] = m_we[1]; m_ld[2] = m_ld[1];
      if (accept[1]) begin
        m_v[1] = leave[0] && !flush;
        m_dest[1] = int'(id_dest); m_we[1] = id_we; m_ld[1] = id_is_load;
      end
      if (accept[0]) m_v[0] = if_ready_go && !flush;
    end
  endtask

  task automatic cycle(input bit rst, input bit ifrg,
                       input int a0, input bit u0, input int a1, input bit u1,
                       input int dest, input bit we, input bit ld,
                       input bit busy, input bit redir);
    reset       = rst;
    if_ready_go = ifrg;
    id_src_addr = {REG_AW'(a1), REG_AW'(a0)};
    id_src_use  = {u1, u0};
    id_dest     = REG_AW'(dest);
    id_we       = we;
    id_is_load  = ld;
    ex_busy     = busy;
    ex_redirect = redir;
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; if_ready_go = 1'b0; id_src_addr = '0; id_src_use = '0;
    id_dest = '0; id_we = 1'b0; id_is_load = 1'b0; ex_busy = 1'b0; ex_redirect = 1'b0;
    @(posedge clk);
    #1;
    model_clear();

    // Reset state, then back-to-back r4 writers and r4 readers.
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 2, 1, 4, 1, 0, 0, 0);
    cycle(0, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    cycle(0, 1, 4, 1, 0, 0, 9, 1, 0, 0, 0);
    cycle(0, 1, 4, 1, 4, 1, 10, 1, 0, 0, 0);
    // Load-use on r5.
    cycle(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    cycle(0, 1, 5, 1, 0, 0, 11, 1, 0, 0, 0);
    cycle(0, 1, 5, 1, 0, 0, 11, 1, 0, 0, 0);
    // Load r6 reaches EX and redirects while ID reads r6.
    cycle(0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    cycle(0, 1, 6, 1, 0, 0, 12, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0);
    // Multi-cycle EX for three cycles.
    repeat (3) cycle(0, 1, 0, 0, 0, 0, 15, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // r0 writer followed by an r0 reader, then an r7 dependency.
    cycle(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 1, 7, 1, 0, 0, 0);
    repeat (5) cycle(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    // Reset with the pipe full.
    repeat (4) cycle(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register range to provoke frequent matches.
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 255) == 0,
            $urandom_range(0, 9) < 8,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control block for the five-stage LoongArch core (IF/ID/EX/MEM/WB).
- Owns the per-stage valid bits and the allowin/ready_go handshake chain.
- Detects RAW hazards against EX/MEM/WB, issues forwarding selects or stalls, and flushes wrong-path instructions on an EX-resolved redirect.
- Sits beside the datapath in the CPU top; datapath pipeline registers load when this block asserts their enables.

Parameters:
REG_AW, 5, register address width
NSRC, 2, number of ID source operands checked for hazards
CNT_W, 32, width of saturating stall/flush performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_ready_go  in  1  IF stage holds a valid fetched instruction
id_src_addr  in  NSRC*REG_AW  ID source register numbers, operand i at [i*REG_AW +: REG_AW]
id_src_use  in  NSRC  operand i is actually read by the ID instruction
id_dest  in  REG_AW  ID destination register
id_we  in  1  ID instruction writes the regfile
id_is_load  in  1  ID instruction is a load (result ready only in MEM)
ex_busy  in  1  multi-cycle EX operation not finished
ex_redirect  in  1  EX instruction redirects the PC (taken branch or jump)
pc_we  out  1  PC and IF/ID register load enable
id_ex_we  out  1  ID/EX register load enable
ex_mem_we  out  1  EX/MEM register load enable
mem_wb_we  out  1  MEM/WB register load enable
stage_valid  out  4  {wb,mem,ex,id} valid bits
fwd_sel  out  NSRC*2  per operand: 0 regfile, 1 EX, 2 MEM, 3 WB
rf_we_wb  out  1  regfile write enable (valid WB with we)
stall_cnt  out  CNT_W  cycles ID was stalled by a hazard
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Internal state:
  - v_id, v_ex, v_mem, v_wb.
  - Per-stage {dest, we, is_load} for EX, MEM and WB, captured from ID on advance.
- Reset: every valid bit is 0, all outputs are 0, and counters are cleared. Reset applied mid-operation discards all in-flight state on the next edge.
- Handshake:
  - wb_allowin = 1.
  - mem_allowin = !v_mem | wb_allowin.
  - ex_allowin = !v_ex | (!ex_busy & mem_allowin).
  - id_allowin = !v_id | (id_ready_go & ex_allowin).
  - pc_we = (if_ready_go & id_allowin) | flush.
  - id_ex_we = ex_allowin.
  - ex_mem_we = mem_allowin.
  - mem_wb_we = 1.
- Valid propagation on each edge:
  - v_wb <= v_mem.
  - v_mem <= v_ex & !ex_busy when mem_allowin.
  - v_ex <= v_id & id_ready_go & !flush when ex_allowin.
  - v_id <= if_ready_go & !flush when id_allowin.
- Hazard match for operand i:
  - Requires id_src_use[i], addr != 0, and stage valid & we & dest == addr.
  - Priority EX > MEM > WB.
  - fwd_sel is combinational and reflects the highest-priority match; it is 0 when there is no match.
- Load-use: an EX match where EX is_load forces id_ready_go = 0, and stall_cnt increments while v_id.
- Flush:
  - flush = v_ex & ex_redirect & !ex_busy.
  - Kills the instruction in ID and the one in IF; the EX instruction itself advances.
  - flush_cnt increments.
  - Flush overrides any simultaneous ID stall.
- Boundaries:
  - ex_busy held: ID/IF are stalled, and the MEM bubble is inserted (v_mem <= 0).
  - Register 0 never matches.
  - Counters saturate at all-ones.
  - A stalled ID keeps re-evaluating hazards every cycle.

Optional Feature:
- Macro: PIPE_FORWARD_EN.
- Defined: forwarding as above; only load-use stalls.
- Undefined:
  - fwd_sel is tied to 0.
  - Any EX, MEM or WB match stalls ID; the regfile is not write-through.
  - Stall lasts until the producer has left WB.

Decomposition:
- Package pipe_pkg holds:
  - The fwd_sel encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
  - The stage index constants.
  - A stage-info struct {dest, we, is_load}.
- One sub-module, hazard_match: a combinational single-operand matcher instantiated NSRC times.

Test Plan:
- Back-to-back add.w r4 writes, then ID reads r4 -> fwd_sel=1, no stall; next cycle a reader of r4 sees fwd_sel=2.
- ld.w r5 in EX, ID reads r5 -> one stall cycle (pc_we=0, id_ex_we=1 with bubble), then fwd_sel=2; stall_cnt=1.
- ex_redirect with v_ex=1, v_id=1 -> next cycle v_id=0 and v_ex=0, pc_we=1; flush_cnt=1; a coincident load-use stall is ignored.
- ex_busy held 3 cycles -> pc_we=0 and id_ex_we=0 for 3 cycles, and v_mem=0 during that window.
- Reader of r0 while EX writes r0 -> fwd_sel=0 and no stall; with PIPE_FORWARD_EN undefined, an r7 dependency on EX stalls 3 cycles.
- Reset asserted with all stages valid -> next cycle stage_valid=0, counters=0, and rf_we_wb=0.
